// File: rtl/stepper_phase_driver_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared types and constants for the stepper phase driver:
//   cmd_t            - decoded rotate command
//   PHASE_TABLE      - 8-entry coil pattern table {A,B,C,D}
//   PHASE_RESET_IDX  - phase index loaded on reset
//   decode_cmd()     - maps the synchronized {right,left} levels to a command
// -----------------------------------------------------------------------------
package stepper_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE = 2'd0,
    CMD_CW   = 2'd1,
    CMD_CCW  = 2'd2
  } cmd_t;

  // Even indices energize one coil, odd indices energize two adjacent coils.
  // Full-step mode walks only the odd entries (two-phase-on, more torque).
  localparam logic [3:0] PHASE_TABLE [8] = '{
    4'b1000, 4'b1100, 4'b0100, 4'b0110,
    4'b0010, 4'b0011, 4'b0001, 4'b1001
  };

  localparam logic [2:0] PHASE_RESET_IDX = 3'd1;

  // Both buttons pressed is treated as "no motion" rather than a priority pick.
  function automatic cmd_t decode_cmd(input logic [1:0] right_left);
    cmd_t cmd;
    case (right_left)
      2'b10:   cmd = CMD_CW;
      2'b01:   cmd = CMD_CCW;
      default: cmd = CMD_IDLE;
    endcase
    return cmd;
  endfunction

endpackage

// File: rtl/stepper_phase_driver_input_sync2.sv
// -----------------------------------------------------------------------------
// input_sync2
// Two-flop synchronizer for level signals crossing into the clk domain.
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; clears both stages
//   d     - asynchronous input levels [WIDTH-1:0]
//   q     - synchronized levels, two cycles of latency
// -----------------------------------------------------------------------------
module input_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/stepper_phase_driver.sv
// -----------------------------------------------------------------------------
// stepper_phase_driver
// Turns the right/left button levels into a paced coil phase sequence for a
// 4-coil stepper, and keeps a signed step count.
// Parameters:
//   STEP_DIV  - clock cycles per motor step (>= 2)
//   HALF_STEP - 0: full-step two-phase-on, 1: 8-state half-step
//   POS_W     - width of the signed position counter
// Ports:
//   clk       - system clock
//   reset     - synchronous, active-high
//   rightLeft - asynchronous button levels, [1]=right, [0]=left
//   enable    - 0 de-energizes the coils and halts stepping
//   coils     - registered coil drive {A,B,C,D}
//   stepPulse - one-cycle pulse coincident with each step's coils update
//   dirOut    - direction of the last step, 1 = CW, 0 = CCW
//   position  - signed step count, wraps in two's complement
// -----------------------------------------------------------------------------
module stepper_phase_driver
  import stepper_pkg::*;
#(
  parameter int STEP_DIV  = 100000,
  parameter int HALF_STEP = 0,
  parameter int POS_W     = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              rightLeft,
  input  logic                    enable,
  output logic [3:0]              coils,
  output logic                    stepPulse,
  output logic                    dirOut,
  output logic signed [POS_W-1:0] position
);

  localparam int                      DIV_W    = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [DIV_W-1:0]        DIV_ONE  = DIV_W'(1);
  localparam logic [2:0]              IDX_INC  = (HALF_STEP != 0) ? 3'd1 : 3'd2;
  localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);

  logic [1:0] rl_sync;
  cmd_t       cmd;
  logic       moving;
  logic       step_evt;

  logic [DIV_W-1:0]        div_d,   div_q;
  logic [2:0]              idx_d,   idx_q;
  logic signed [POS_W-1:0] pos_d,   pos_q;
  logic                    dir_d,   dir_q;
  logic                    pulse_d, pulse_q;
  logic [3:0]              coils_d, coils_q;

  input_sync2 #(.WIDTH(2)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rightLeft),
    .q     (rl_sync)
  );

  always_comb begin
    cmd      = decode_cmd(rl_sync);
    moving   = enable && (cmd != CMD_IDLE);
    step_evt = moving && (div_q == DIV_LAST);

    // A direction change keeps counting: only idle/disable or a step clears it.
    if (!moving || step_evt) div_d = '0;
    else                     div_d = div_q + DIV_ONE;

    idx_d = idx_q;
    pos_d = pos_q;
    dir_d = dir_q;
    if (step_evt) begin
      if (cmd == CMD_CW) begin
        idx_d = idx_q + IDX_INC;
        pos_d = pos_q + POS_ONE;
        dir_d = 1'b1;
      end else begin
        idx_d = idx_q - IDX_INC;
        pos_d = pos_q - POS_ONE;
        dir_d = 1'b0;
      end
    end

    pulse_d = step_evt;
    // Look up with the next index so the coils change on the same edge as
    // stepPulse rather than one cycle later.
    coils_d = enable ? PHASE_TABLE[idx_d] : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= PHASE_RESET_IDX;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
      coils_q <= 4'b0000;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      pulse_q <= pulse_d;
      coils_q <= coils_d;
    end
  end

  assign coils     = coils_q;
  assign stepPulse = pulse_q;
  assign dirOut    = dir_q;
  assign position  = pos_q;

endmodule

// File: tb/tb_stepper_phase_driver.sv
// -----------------------------------------------------------------------------
// tb_stepper_phase_driver
// Directed bench for stepper_phase_driver. Two instances share all inputs:
//   u_fs - full-step, POS_W=4 (small width to reach the position wrap quickly)
//   u_hs - half-step, POS_W=16
// Both use STEP_DIV=4.
// -----------------------------------------------------------------------------
module tb_stepper_phase_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rightLeft;
  logic       enable;

  logic [3:0]         coils_fs, coils_hs;
  logic               pulse_fs, pulse_hs;
  logic               dir_fs,   dir_hs;
  logic signed [3:0]  pos_fs;
  logic signed [15:0] pos_hs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stepper_phase_driver #(.STEP_DIV(4), .HALF_STEP(0), .POS_W(4)) u_fs (
    .clk       (clk),
    .reset     (reset),
    .rightLeft (rightLeft),
    .enable    (enable),
    .coils     (coils_fs),
    .stepPulse (pulse_fs),
    .dirOut    (dir_fs),
    .position  (pos_fs)
  );

  stepper_phase_driver #(.STEP_DIV(4), .HALF_STEP(1), .POS_W(16)) u_hs (
    .clk       (clk),
    .reset     (reset),
    .rightLeft (rightLeft),
    .enable    (enable),
    .coils     (coils_hs),
    .stepPulse (pulse_hs),
    .dirOut    (dir_hs),
    .position  (pos_hs)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h) at %0t",
               tag, $signed(obs), obs, $signed(exp), exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] get_coils(input int sel);
    return (sel == 0) ? 32'(coils_fs) : 32'(coils_hs);
  endfunction

  function automatic logic [31:0] get_pulse(input int sel);
    return (sel == 0) ? 32'(pulse_fs) : 32'(pulse_hs);
  endfunction

  function automatic logic [31:0] get_dir(input int sel);
    return (sel == 0) ? 32'(dir_fs) : 32'(dir_hs);
  endfunction

  function automatic logic [31:0] get_pos(input int sel);
    return (sel == 0) ? 32'(pos_fs) : 32'(pos_hs);
  endfunction

  // gap-1 quiet cycles, then a cycle that must carry the step.
  task automatic expect_step(input int sel, input int gap, input logic [3:0] c,
                             input int p, input logic d);
    for (int i = 0; i < gap - 1; i++) begin
      tick();
      check_val("quiet_pulse", get_pulse(sel), 32'd0);
    end
    tick();
    check_val("step_pulse", get_pulse(sel), 32'd1);
    check_val("step_coils", get_coils(sel), 32'(c));
    check_val("step_pos",   get_pos(sel),   32'(p));
    check_val("step_dir",   get_dir(sel),   32'(d));
  endtask

  task automatic check_reset_state(input int sel);
    check_val("rst_coils", get_coils(sel), 32'd0);
    check_val("rst_pulse", get_pulse(sel), 32'd0);
    check_val("rst_dir",   get_dir(sel),   32'd0);
    check_val("rst_pos",   get_pos(sel),   32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] fs_cw [4];
    logic [3:0] hs_ccw [3];
    fs_cw  = '{4'b0011, 4'b1001, 4'b1100, 4'b0110};
    hs_ccw = '{4'b1001, 4'b0001, 4'b0011};

    reset     = 1'b1;
    rightLeft = 2'b00;
    enable    = 1'b1;

    // Full-step CW: reset state, first phase, latency and sequence.
    tick(); tick();
    check_reset_state(0);
    check_reset_state(1);
    reset = 1'b0;
    tick();
    check_val("first_coils", get_coils(0), 32'h0000000C);
    rightLeft = 2'b10;
    expect_step(0, 6, 4'b0110, 1, 1'b1);
    for (int k = 0; k < 3; k++)
      expect_step(0, 4, fs_cw[k], 2 + k, 1'b1);

    // Half-step CCW from reset.
    reset     = 1'b1;
    rightLeft = 2'b01;
    tick(); tick();
    check_reset_state(1);
    reset = 1'b0;
    expect_step(1, 6, 4'b1000, -1, 1'b0);
    for (int k = 0; k < 3; k++)
      expect_step(1, 4, hs_ccw[k], -2 - k, 1'b0);

    // Both buttons, then none: no motion at all.
    reset     = 1'b1;
    rightLeft = 2'b11;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val("both_pulse", get_pulse(0), 32'd0);
      check_val("both_coils", get_coils(0), 32'h0000000C);
    end
    rightLeft = 2'b00;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_val("none_pulse", get_pulse(0), 32'd0);
      check_val("none_coils", get_coils(0), 32'h0000000C);
    end
    check_val("none_pos", get_pos(0), 32'd0);

    // Reverse while the synced command sits at divCnt=2: step keeps its timing.
    rightLeft = 2'b10;
    tick();
    check_val("rev_pulse_a", get_pulse(0), 32'd0);
    tick();
    check_val("rev_pulse_b", get_pulse(0), 32'd0);
    rightLeft = 2'b01;
    expect_step(0, 4, 4'b1001, -1, 1'b0);
    expect_step(0, 4, 4'b0011, -2, 1'b0);

    // Disable mid-run, then re-enable.
    enable = 1'b0;
    tick();
    check_val("dis_coils", get_coils(0), 32'd0);
    check_val("dis_pulse", get_pulse(0), 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_val("dis_hold_pulse", get_pulse(0), 32'd0);
      check_val("dis_hold_coils", get_coils(0), 32'd0);
      check_val("dis_hold_pos",   get_pos(0),   32'(-2));
    end
    enable = 1'b1;
    tick();
    check_val("reen_coils", get_coils(0), 32'h00000003);
    check_val("reen_pulse", get_pulse(0), 32'd0);
    expect_step(0, 3, 4'b0110, -3, 1'b0);

    // Position wrap on the 4-bit counter: 7 -> -8.
    reset     = 1'b1;
    rightLeft = 2'b10;
    tick(); tick();
    reset = 1'b0;
    expect_step(0, 6, 4'b0110, 1, 1'b1);
    for (int k = 0; k < 7; k++)
      expect_step(0, 4, fs_cw[k % 4], (k < 6) ? (2 + k) : -8, 1'b1);

    // Reset mid-count discards the pending step.
    tick(); tick();
    reset = 1'b1;
    tick();
    check_reset_state(0);
    reset = 1'b0;
    tick();
    check_val("post_rst_coils", get_coils(0), 32'h0000000C);
    check_val("post_rst_pos",   get_pos(0),   32'd0);
    expect_step(0, 5, 4'b0110, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
